// File: rtl/minimum_second_minimum_calculator.sv
// Finds the smallest entry, its index, and the smallest entry at any other index.
// A small FSM/counter sequences two passes over the entries; the data path only compares and loads.
module minimum_second_minimum_calculator #(
    parameter int N  = 40,
    parameter int W  = 32,
    parameter int PW = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_row_processing,
    input  logic [N*W-1:0] inputs,
    output logic [W-1:0]   min,
    output logic [PW-1:0]  pos,
    output logic [W-1:0]   second_min,
    output logic           done_row_processing,
    output logic           busy
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        INIT_MIN    = 3'd1,
        SCAN_MIN    = 3'd2,
        INIT_SECOND = 3'd3,
        SCAN_SECOND = 3'd4,
        DONE        = 3'd5
    } state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   count_reg;
    logic [W-1:0]    min_reg, second_min_reg;
    logic [PW-1:0]   pos_reg;
    logic            done_reg;

    logic initialize_min, initialize_second_min, reset_count;
    logic calculating_second_min, load_first_min, load_second_min;
    logic done_iterations;

    // Unused slots above N read as all ones so the mux index never leaves the array.
    logic [W-1:0] entries [0:(2**PW)-1];
    generate
        for (genvar gi = 0; gi < 2**PW; gi++) begin : g_entries
            if (gi < N) begin : g_real
                assign entries[gi] = inputs[gi*W +: W];
            end else begin : g_pad
                assign entries[gi] = '1;
            end
        end
    endgenerate

    logic [W-1:0] entry_sel;
    assign entry_sel = entries[count_reg];

    // ---------------- control path ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:        if (start_row_processing) state_next = INIT_MIN;
            INIT_MIN:    state_next = SCAN_MIN;
            SCAN_MIN:    if (done_iterations) state_next = INIT_SECOND;
            INIT_SECOND: state_next = SCAN_SECOND;
            SCAN_SECOND: if (done_iterations) state_next = DONE;
            DONE:        state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end

    always_comb begin
        initialize_min         = (state_reg == INIT_MIN);
        initialize_second_min  = (state_reg == INIT_SECOND);
        reset_count            = (state_reg == INIT_SECOND);
        load_first_min         = (state_reg == SCAN_MIN);
        calculating_second_min = (state_reg == SCAN_SECOND);
        // The second pass skips the slot that currently holds the minimum.
        load_second_min        = calculating_second_min && (count_reg != pos_reg);
        busy                   = (state_reg != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (initialize_min) begin
            count_reg <= PW'(1);
        end else if (reset_count) begin
            count_reg <= '0;
        end else if (load_first_min || calculating_second_min) begin
            count_reg <= count_reg + PW'(1);
        end
    end

    assign done_iterations = (count_reg == PW'(N - 1));

    // ---------------- data path ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            min_reg        <= '0;
            pos_reg        <= '0;
            second_min_reg <= '0;
            done_reg       <= 1'b0;
        end else begin
            if (initialize_min) begin
                min_reg <= entries[0];
                pos_reg <= '0;
            end else if (load_first_min && (entry_sel < min_reg)) begin
                min_reg <= entry_sel;
                pos_reg <= count_reg;
            end

            if (initialize_second_min) begin
                second_min_reg <= '1;
            end else if (load_second_min && (entry_sel < second_min_reg)) begin
                second_min_reg <= entry_sel;
            end

            done_reg <= (state_reg == DONE);
        end
    end

    assign min                 = min_reg;
    assign pos                 = pos_reg;
    assign second_min          = second_min_reg;
    assign done_row_processing = done_reg;

endmodule

// File: tb/tb_minimum_second_minimum_calculator.sv
// Directed bench for minimum_second_minimum_calculator: one task per scenario,
// each comparing outputs against hand-computed values.
module tb_minimum_second_minimum_calculator;

    localparam int N  = 40;
    localparam int W  = 32;
    localparam int PW = 6;

    logic           clk;
    logic           rst_n;
    logic           start_row_processing;
    logic [N*W-1:0] inputs;
    logic [W-1:0]   min;
    logic [PW-1:0]  pos;
    logic [W-1:0]   second_min;
    logic           done_row_processing;
    logic           busy;

    int checks = 0;
    int errors = 0;

    minimum_second_minimum_calculator #(.N(N), .W(W), .PW(PW)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start_row_processing (start_row_processing),
        .inputs               (inputs),
        .min                  (min),
        .pos                  (pos),
        .second_min           (second_min),
        .done_row_processing  (done_row_processing),
        .busy                 (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulses start for one edge, then counts edges until done is seen (#1 after each edge).
    task automatic run_row(output int lat);
        @(negedge clk);
        start_row_processing = 1'b1;
        @(posedge clk);
        #1;
        start_row_processing = 1'b0;
        lat = 0;
        while (1) begin
            @(posedge clk);
            #1;
            lat++;
            if (done_row_processing) break;
            if (lat > 300) begin
                lat = -1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_row_processing = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (min !== '0) begin errors++; $display("FAIL reset_min actual=%0h required=0", min); end
        checks++; if (pos !== '0) begin errors++; $display("FAIL reset_pos actual=%0d required=0", pos); end
        checks++; if (second_min !== '0) begin errors++; $display("FAIL reset_second_min actual=%0h required=0", second_min); end
        checks++; if (done_row_processing !== 1'b0) begin errors++; $display("FAIL reset_done actual=%b required=0", done_row_processing); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy actual=%b required=0", busy); end
        start_row_processing = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("test_reset: min=%0h pos=%0d second_min=%0h busy=%b", min, pos, second_min, busy);
    endtask

    task automatic test_ascending();
        int lat;
        for (int i = 0; i < N; i++) inputs[i*W +: W] = 32'(i + 5);
        run_row(lat);
        checks++; if (lat !== 82) begin errors++; $display("FAIL asc_latency actual=%0d required=82", lat); end
        checks++; if (min !== 32'd5) begin errors++; $display("FAIL asc_min actual=%0d required=5", min); end
        checks++; if (pos !== 6'd0) begin errors++; $display("FAIL asc_pos actual=%0d required=0", pos); end
        checks++; if (second_min !== 32'd6) begin errors++; $display("FAIL asc_second_min actual=%0d required=6", second_min); end
        @(posedge clk);
        #1;
        checks++; if (done_row_processing !== 1'b0) begin errors++; $display("FAIL asc_done_width actual=%b required=0", done_row_processing); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL asc_busy_after actual=%b required=0", busy); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (min !== 32'd5 || second_min !== 32'd6) begin errors++; $display("FAIL asc_hold actual=%0d/%0d required=5/6", min, second_min); end
        $display("test_ascending: latency=%0d min=%0d pos=%0d second_min=%0d", lat, min, pos, second_min);
    endtask

    task automatic test_last_min();
        int lat;
        for (int i = 0; i < N; i++) inputs[i*W +: W] = 32'(100 + i);
        inputs[39*W +: W] = 32'd1;
        inputs[17*W +: W] = 32'd2;
        run_row(lat);
        checks++; if (min !== 32'd1) begin errors++; $display("FAIL last_min actual=%0d required=1", min); end
        checks++; if (pos !== 6'b100111) begin errors++; $display("FAIL last_pos actual=%0d required=39", pos); end
        checks++; if (second_min !== 32'd2) begin errors++; $display("FAIL last_second_min actual=%0d required=2", second_min); end
        $display("test_last_min: latency=%0d min=%0d pos=%0d second_min=%0d", lat, min, pos, second_min);
    endtask

    task automatic test_ties();
        int lat;
        for (int i = 0; i < N; i++) inputs[i*W +: W] = 32'd50;
        inputs[3*W +: W]  = 32'd7;
        inputs[20*W +: W] = 32'd7;
        run_row(lat);
        checks++; if (min !== 32'd7) begin errors++; $display("FAIL ties_min actual=%0d required=7", min); end
        checks++; if (pos !== 6'd3) begin errors++; $display("FAIL ties_pos actual=%0d required=3", pos); end
        checks++; if (second_min !== 32'd7) begin errors++; $display("FAIL ties_second_min actual=%0d required=7", second_min); end
        $display("test_ties: latency=%0d min=%0d pos=%0d second_min=%0d", lat, min, pos, second_min);
    endtask

    task automatic test_all_ones();
        int lat;
        for (int i = 0; i < N; i++) inputs[i*W +: W] = 32'hFFFF_FFFF;
        run_row(lat);
        checks++; if (min !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ones_min actual=%0h required=ffffffff", min); end
        checks++; if (pos !== 6'd0) begin errors++; $display("FAIL ones_pos actual=%0d required=0", pos); end
        checks++; if (second_min !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ones_second_min actual=%0h required=ffffffff", second_min); end
        $display("test_all_ones: latency=%0d min=%0h pos=%0d second_min=%0h", lat, min, pos, second_min);
    endtask

    task automatic test_ignore_start();
        int done_count = 0;
        int done_cycle = -1;
        for (int i = 0; i < N; i++) inputs[i*W +: W] = 32'(1000 - i);
        @(negedge clk);
        start_row_processing = 1'b1;
        @(posedge clk);
        #1;
        start_row_processing = 1'b0;
        for (int c = 1; c <= 120; c++) begin
            if (c == 10) start_row_processing = 1'b1;
            @(posedge clk);
            #1;
            start_row_processing = 1'b0;
            if (done_row_processing) begin
                done_count++;
                if (done_cycle < 0) done_cycle = c;
            end
        end
        checks++; if (done_count !== 1) begin errors++; $display("FAIL ignore_done_count actual=%0d required=1", done_count); end
        checks++; if (done_cycle !== 82) begin errors++; $display("FAIL ignore_done_cycle actual=%0d required=82", done_cycle); end
        checks++; if (min !== 32'd961 || pos !== 6'd39 || second_min !== 32'd962) begin
            errors++; $display("FAIL ignore_result actual=%0d/%0d/%0d required=961/39/962", min, pos, second_min);
        end
        $display("test_ignore_start: dones=%0d cycle=%0d min=%0d pos=%0d", done_count, done_cycle, min, pos);
    endtask

    task automatic test_reset_abort();
        int lat;
        int done_count = 0;
        for (int i = 0; i < N; i++) inputs[i*W +: W] = 32'(200 + i);
        inputs[12*W +: W] = 32'd3;
        @(negedge clk);
        start_row_processing = 1'b1;
        @(posedge clk);
        #1;
        start_row_processing = 1'b0;
        for (int c = 1; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (done_row_processing) done_count++;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++; if (min !== '0) begin errors++; $display("FAIL abort_min actual=%0h required=0", min); end
        checks++; if (pos !== '0) begin errors++; $display("FAIL abort_pos actual=%0d required=0", pos); end
        checks++; if (second_min !== '0) begin errors++; $display("FAIL abort_second_min actual=%0h required=0", second_min); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy actual=%b required=0", busy); end
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (done_row_processing) done_count++;
        end
        checks++; if (done_count !== 0) begin errors++; $display("FAIL abort_no_done actual=%0d required=0", done_count); end
        run_row(lat);
        checks++; if (lat !== 82) begin errors++; $display("FAIL abort_restart_latency actual=%0d required=82", lat); end
        checks++; if (min !== 32'd3 || pos !== 6'd12 || second_min !== 32'd200) begin
            errors++; $display("FAIL abort_restart_result actual=%0d/%0d/%0d required=3/12/200", min, pos, second_min);
        end
        $display("test_reset_abort: latency=%0d min=%0d pos=%0d second_min=%0d", lat, min, pos, second_min);
    endtask

    initial begin
        rst_n = 1'b0;
        start_row_processing = 1'b0;
        inputs = '0;
        test_reset();
        test_ascending();
        test_last_min();
        test_ties();
        test_all_ones();
        test_ignore_start();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/minimum_second_minimum_calculator.md
MINIMUM_SECOND_MINIMUM_CALCULATOR -- requirements
Module: minimum_second_minimum_calculator

Interface
REQ-001 Parameter N, default 40, number of input entries.
REQ-002 Parameter W, default 32, entry width in bits; entries are unsigned magnitudes.
REQ-003 Parameter PW, default 6, position width; 2^PW SHALL be >= N.
REQ-004 clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-005 rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-006 start_row_processing  input  1  start request, sampled on a rising edge.
REQ-007 inputs  input  N*W  entry i SHALL occupy bits [i*W+W-1 : i*W].
REQ-008 min  output  W  smallest entry.
REQ-009 pos  output  PW  index of min.
REQ-010 second_min  output  W  smallest entry excluding index pos.
REQ-011 done_row_processing  output  1  one-cycle completion pulse.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The block SHALL be split internally into a control path (FSM plus counter) and a data path (comparators plus registers), connected by the strobes initialize_min, initialize_second_min, reset_count, calculating_second_min, load_first_min, load_second_min and done_iterations.
REQ-014 FSM states: IDLE, INIT_MIN, SCAN_MIN, INIT_SECOND, SCAN_SECOND, DONE.
REQ-015 IDLE: if start_row_processing=1, go to INIT_MIN; otherwise stay in IDLE.
REQ-016 INIT_MIN (1 cycle): min <= entry 0; pos <= 0; count <= 1; then go to SCAN_MIN.
REQ-017 SCAN_MIN (N-1 cycles, count 1..N-1): if entry[count] < min (strict), load min <= entry[count] and pos <= count; increment count; done_iterations is asserted when count = N-1; after that cycle go to INIT_SECOND.
REQ-018 INIT_SECOND (1 cycle): second_min <= all ones (2^W-1); count <= 0; then go to SCAN_SECOND.
REQ-019 SCAN_SECOND (N cycles, count 0..N-1): if count != pos and entry[count] < second_min, load second_min <= entry[count]; after count = N-1, go to DONE.
REQ-020 DONE (1 cycle): assert done_row_processing=1; then go to IDLE.
REQ-021 Latency: done_row_processing SHALL be high exactly 2N+2 cycles (82 for N=40) after the edge that sampled start_row_processing.
REQ-022 Ties: the lowest index wins for min. A duplicate of min at another index SHALL make second_min equal min.
REQ-023 If every entry other than pos equals 2^W-1, second_min SHALL be 2^W-1.
REQ-024 start_row_processing SHALL be ignored while busy=1.
REQ-025 inputs SHALL be held stable by the user while busy=1; the block does not capture them.
REQ-026 min, pos and second_min SHALL hold their values from DONE until the next INIT_MIN or INIT_SECOND reloads them.
REQ-027 During processing, the outputs show intermediate values; they are valid only from the DONE cycle onward.
REQ-028 Counter width SHALL be PW; comparisons SHALL be unsigned and full W bits wide.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force: state IDLE, count=0, min=0, pos=0, second_min=0, done_row_processing=0, busy=0.
REQ-030 Reset SHALL take priority over start_row_processing and over any in-progress scan; the aborted operation produces no done pulse.
REQ-031 After rst_n returns to 1, the block SHALL accept a start on the next edge.

Verification
REQ-032 Entry i = i+5; pulse start -> min=5, pos=0, second_min=6; done high exactly 82 cycles after the start edge.
REQ-033 Entries = 100+i, except entry 39 = 1 and entry 17 = 2 -> min=1, pos=6'b100111, second_min=2.
REQ-034 Entries = 50, except entries 3 and 20 = 7 -> min=7, pos=3, second_min=7.
REQ-035 All entries = 0xFFFFFFFF -> min=0xFFFFFFFF, pos=0, second_min=0xFFFFFFFF.
REQ-036 Start pulse, then a second start at cycle 10 -> the second start is ignored; a single done pulse at cycle 82.
REQ-037 Start, then rst_n=0 at cycle 30 -> outputs 0 and state IDLE; no done pulse; a new start then completes normally.
